// File: rtl/fsk_mod_if.sv
// fsk_mod_if: bit-source handshake and sample stream of the FSK modulator.
// master = upstream/consumer side, slave = the modulator.
interface fsk_mod_if;
  logic              en;
  logic              code;
  logic              bit_tick;
  logic              cur_bit;
  logic signed [7:0] fsk_out;
  logic              out_valid;

  modport master (output en, code, input bit_tick, cur_bit, fsk_out, out_valid);
  modport slave  (input en, code, output bit_tick, cur_bit, fsk_out, out_valid);
endinterface

// File: rtl/fsk_mod.sv
// fsk_mod: binary FSK modulator. Requests a source bit per symbol with
// bit_tick, steps a phase accumulator by F0_WORD/F1_WORD and maps the top
// 8 phase bits through a quarter-wave sine table to a signed 8-bit sample.
// Build option FSK_PHASE_CONT_EN: phase-continuous accumulation across
// symbol boundaries; undefined (default) restarts phase at 0 each symbol.
//
// state  | meaning
// S_IDLE | modulator off, cnt/acc held at 0, outputs flush to 0
// S_RUN  | symbol counter running, accumulator stepping every clock
module fsk_mod #(
  parameter int          PHASE_W  = 16,
  parameter int unsigned F0_WORD  = 32'h0400,
  parameter int unsigned F1_WORD  = 32'h0800,
  parameter int          BIT_CLKS = 64
) (
  input logic      clk,
  input logic      rst_n,
  fsk_mod_if.slave bus
);

  localparam int CNT_W = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PHASE_W-1:0]  acc_q, acc_d;
  logic                cur_bit_q, cur_bit_d;
  logic                bit_tick_q, bit_tick_d;
  logic signed [7:0]   fsk_out_q;
  logic                out_valid_q;
  logic                run;
  logic                sym_end;
  logic [PHASE_W-1:0]  inc;

  // First quadrant magnitude: round(127*sin(pi*i/128)), i = 0..63.
  function automatic logic [6:0] sine_lut(input logic [5:0] i);
    logic [6:0] v;
    case (i)
      6'd0:  v = 7'd0;   6'd1:  v = 7'd3;   6'd2:  v = 7'd6;   6'd3:  v = 7'd9;
      6'd4:  v = 7'd12;  6'd5:  v = 7'd16;  6'd6:  v = 7'd19;  6'd7:  v = 7'd22;
      6'd8:  v = 7'd25;  6'd9:  v = 7'd28;  6'd10: v = 7'd31;  6'd11: v = 7'd34;
      6'd12: v = 7'd37;  6'd13: v = 7'd40;  6'd14: v = 7'd43;  6'd15: v = 7'd46;
      6'd16: v = 7'd49;  6'd17: v = 7'd51;  6'd18: v = 7'd54;  6'd19: v = 7'd57;
      6'd20: v = 7'd60;  6'd21: v = 7'd63;  6'd22: v = 7'd65;  6'd23: v = 7'd68;
      6'd24: v = 7'd71;  6'd25: v = 7'd73;  6'd26: v = 7'd76;  6'd27: v = 7'd78;
      6'd28: v = 7'd81;  6'd29: v = 7'd83;  6'd30: v = 7'd85;  6'd31: v = 7'd88;
      6'd32: v = 7'd90;  6'd33: v = 7'd92;  6'd34: v = 7'd94;  6'd35: v = 7'd96;
      6'd36: v = 7'd98;  6'd37: v = 7'd100; 6'd38: v = 7'd102; 6'd39: v = 7'd104;
      6'd40: v = 7'd106; 6'd41: v = 7'd107; 6'd42: v = 7'd109; 6'd43: v = 7'd111;
      6'd44: v = 7'd112; 6'd45: v = 7'd113; 6'd46: v = 7'd115; 6'd47: v = 7'd116;
      6'd48: v = 7'd117; 6'd49: v = 7'd118; 6'd50: v = 7'd120; 6'd51: v = 7'd121;
      6'd52: v = 7'd122; 6'd53: v = 7'd122; 6'd54: v = 7'd123; 6'd55: v = 7'd124;
      6'd56: v = 7'd125; 6'd57: v = 7'd125; 6'd58: v = 7'd126; 6'd59: v = 7'd126;
      6'd60: v = 7'd126; 6'd61: v = 7'd127; 6'd62: v = 7'd127; 6'd63: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Quadrant unfolding: q1/q3 mirror the index, q2/q3 negate.
  // i==0 in q1/q3 is the peak, which the 64-entry table cannot index.
  function automatic logic signed [7:0] phase_to_sample(input logic [7:0] p);
    logic [5:0] i;
    logic [6:0] mag;
    i = p[5:0];
    if (p[6]) begin
      mag = (i == 6'd0) ? 7'd127 : sine_lut(6'(7'd64 - {1'b0, i}));
    end else begin
      mag = sine_lut(i);
    end
    return p[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  assign run     = (state_q == S_RUN);
  assign sym_end = (cnt_q == CNT_W'(BIT_CLKS - 1));
  assign inc     = cur_bit_q ? PHASE_W'(F1_WORD) : PHASE_W'(F0_WORD);

  // State, symbol counter, phase and current bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      cur_bit_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      cur_bit_q  <= cur_bit_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  // Next-state: start on en, count symbols, step or restart the phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    cur_bit_d  = cur_bit_q;
    bit_tick_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          acc_d      = '0;
          cur_bit_d  = bus.code;
          bit_tick_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else if (sym_end) begin
          cnt_d      = '0;
          cur_bit_d  = bus.code;
          bit_tick_d = 1'b1;
`ifdef FSK_PHASE_CONT_EN
          acc_d      = acc_q + inc;
`else
          acc_d      = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = acc_q + inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output stage: one cycle of phase-to-sample latency; idle phase maps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsk_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsk_out_q   <= phase_to_sample(acc_q[PHASE_W-1 -: 8]);
      out_valid_q <= run;
    end
  end

  assign bus.bit_tick  = bit_tick_q;
  assign bus.cur_bit   = cur_bit_q;
  assign bus.fsk_out   = fsk_out_q;
  assign bus.out_valid = out_valid_q;

endmodule
